// File: rtl/eeprom_page_writer.sv
// Write sequencer for the AT24C08: splits a byte run into page-bounded i2c_mmaster
// bursts and waits out the EEPROM internal write time after each one.
module eeprom_page_writer #(
  parameter int unsigned PAGE_BITS   = 4,
  parameter int unsigned TWR_CYCLES  = 2000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [9:0]  adr_i,
  input  logic [10:0] len_i,
  input  logic        busy_i,
  input  logic        newdat_i,
  output logic        enable_o,
  output logic        rw_o,
  output logic        ur_o,
  output logic [6:0]  devadr_o,
  output logic [7:0]  regadr_o,
  output logic [15:0] datnum_o,
  output logic [9:0]  bufadr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned TimerMax = (TWR_CYCLES > ACK_TIMEOUT) ? TWR_CYCLES : ACK_TIMEOUT;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  localparam logic [PAGE_BITS:0] PageSizeW = {1'b1, {PAGE_BITS{1'b0}}};
  localparam logic [TimerW-1:0]  AckLast   = TimerW'(ACK_TIMEOUT - 1);
  localparam logic [TimerW-1:0]  TwrLast   = TimerW'(TWR_CYCLES - 1);
  localparam logic [TimerW-1:0]  TimerOne  = TimerW'(1);

  typedef enum logic [2:0] {StIdle, StCalc, StReq, StRun, StTwr, StFin} state_e;

  state_e             r_state, w_state_next;
  logic [9:0]         r_cur_adr;
  logic [10:0]        r_rem;
  logic [TimerW-1:0]  r_timer;
  logic [15:0]        r_datnum;
  logic [9:0]         r_bufadr;
  logic               r_enable, r_busy, r_done, r_err;

  logic [10:0]        w_len;
  logic [PAGE_BITS:0] w_room;
  logic [10:0]        w_room_ext;
  logic [10:0]        w_chunk;
  logic               w_ack_expired, w_twr_expired;

  assign w_len         = (len_i > 11'd1024) ? 11'd1024 : len_i;
  // Bytes left before the next page boundary; never zero.
  assign w_room        = PageSizeW - {1'b0, r_cur_adr[PAGE_BITS-1:0]};
  assign w_room_ext    = {{(10 - PAGE_BITS){1'b0}}, w_room};
  assign w_chunk       = (r_rem < w_room_ext) ? r_rem : w_room_ext;
  assign w_ack_expired = (r_timer == AckLast);
  assign w_twr_expired = (r_timer == TwrLast);

  always_ff @(posedge clock_i) begin
    if (reset_i) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (start_i) w_state_next = (len_i == 11'd0) ? StFin : StCalc;
      StCalc: w_state_next = StReq;
      StReq: begin
        if (busy_i)             w_state_next = StRun;
        else if (w_ack_expired) w_state_next = StFin;
      end
      StRun:  if (!busy_i) w_state_next = StTwr;
      StTwr:  if (w_twr_expired) w_state_next = (r_rem == 11'd0) ? StFin : StCalc;
      StFin:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_cur_adr <= '0;
      r_rem     <= '0;
      r_timer   <= '0;
      r_datnum  <= '0;
      r_bufadr  <= '0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_cur_adr <= adr_i;
            r_rem     <= w_len;
            r_bufadr  <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        StCalc: begin
          r_datnum <= {5'd0, w_chunk};
          r_timer  <= '0;
          r_enable <= 1'b1;
        end
        StReq: begin
          if (busy_i) begin
            r_enable <= 1'b0;
          end else if (w_ack_expired) begin
            r_enable <= 1'b0;
            r_err    <= 1'b1;
          end else begin
            r_timer <= r_timer + TimerOne;
          end
        end
        StRun: begin
          if (newdat_i) r_bufadr <= r_bufadr + 10'd1;
          if (!busy_i) begin
            // 10-bit add wraps 1023 -> 0 like the EEPROM address counter.
            r_cur_adr <= r_cur_adr + r_datnum[9:0];
            r_rem     <= r_rem - r_datnum[10:0];
            r_timer   <= '0;
          end
        end
        StTwr: begin
          if (!w_twr_expired) r_timer <= r_timer + TimerOne;
        end
        StFin: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign enable_o = r_enable;
  assign rw_o     = 1'b0;
  assign ur_o     = 1'b1;
  assign devadr_o = {5'b10100, r_cur_adr[9:8]};
  assign regadr_o = r_cur_adr[7:0];
  assign datnum_o = r_datnum;
  assign bufadr_o = r_bufadr;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign err_o    = r_err;

endmodule

// File: tb/tb_eeprom_page_writer.sv
// Randomised bench for eeprom_page_writer: an i2c_mmaster stand-in answers each burst and
// a page-splitting reference model predicts every burst, the buffer address and timing.
module tb_eeprom_page_writer;
  localparam int TWR = 40;
  localparam int ACK = 20;

  logic        clock_i = 1'b0;
  logic        reset_i, start_i, busy_i, newdat_i;
  logic [9:0]  adr_i;
  logic [10:0] len_i;
  logic        enable_o, rw_o, ur_o, busy_o, done_o, err_o;
  logic [6:0]  devadr_o;
  logic [7:0]  regadr_o;
  logic [15:0] datnum_o;
  logic [9:0]  bufadr_o;

  always #5 clock_i = ~clock_i;

  eeprom_page_writer #(
    .PAGE_BITS  (4),
    .TWR_CYCLES (TWR),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .adr_i   (adr_i),
    .len_i   (len_i),
    .busy_i  (busy_i),
    .newdat_i(newdat_i),
    .enable_o(enable_o),
    .rw_o    (rw_o),
    .ur_o    (ur_o),
    .devadr_o(devadr_o),
    .regadr_o(regadr_o),
    .datnum_o(datnum_o),
    .bufadr_o(bufadr_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  typedef struct {
    int dev;
    int regadr;
    int num;
  } burst_t;

  burst_t mq[$];
  burst_t exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en = 0, m_respond = 1, m_active = 0, m_counting = 0;
  bit first_burst = 0, exp_done_gap = 0;
  int exp_buf = 0, start_cyc = 0, end_cyc = 0, rise_cyc = 0, en_cnt = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Page-splitting reference: chunks never cross a 16-byte boundary, address wraps at 1 KiB.
  task automatic model_bursts(input int adr, input int len);
    int a, r, room, c;
    burst_t b;
    mq.delete();
    a = adr;
    r = (len > 1024) ? 1024 : len;
    while (r > 0) begin
      room = 16 - (a % 16);
      c = (r < room) ? r : room;
      b.dev = 'h50 + a / 256;
      b.regadr = a % 256;
      b.num = c;
      mq.push_back(b);
      a = (a + c) % 1024;
      r -= c;
    end
  endtask

  initial forever begin
    @(posedge clock_i);
    cyc++;
  end

  // i2c_mmaster stand-in, plus stray busy/newdat activity while the writer is waiting tWR.
  initial begin
    int n, d, g;
    bit coincide;
    busy_i = 1'b0;
    newdat_i = 1'b0;
    forever begin
      @(posedge clock_i); #1;
      if (enable_o && m_respond) begin
        n = int'(datnum_o);
        d = $urandom_range(0, 2);
        repeat (d) begin @(posedge clock_i); #1; end
        busy_i = 1'b1; m_active = 1; m_counting = 1;
        coincide = 1'($urandom_range(0, 1));
        @(posedge clock_i); #1;
        for (int i = 0; i < n; i++) begin
          g = $urandom_range(0, 2);
          repeat (g) begin @(posedge clock_i); #1; end
          newdat_i = 1'b1;
          if (i == n - 1 && coincide) begin busy_i = 1'b0; m_active = 0; end
          @(posedge clock_i); #1;
          newdat_i = 1'b0;
        end
        m_counting = 0;
        if (busy_i) begin
          busy_i = 1'b0; m_active = 0;
          @(posedge clock_i); #1;
        end
        repeat (3) begin @(posedge clock_i); #1; end
        busy_i = 1'b1; newdat_i = 1'b1;
        @(posedge clock_i); #1;
        busy_i = 1'b0; newdat_i = 1'b0;
      end
    end
  end

  // Compare process.
  initial begin
    logic prev_en = 1'b0, prev_done = 1'b0;
    bit prev_active = 0;
    burst_t b;
    forever begin
      @(negedge clock_i);
      if (chk_en) begin
        if (busy_o) check("bufadr", bufadr_o, 32'(exp_buf % 1024));
        if (enable_o && !prev_en) begin
          en_cnt++;
          rise_cyc = cyc;
          check("rw", rw_o, 0);
          check("ur", ur_o, 1);
          check("burst_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("devadr", devadr_o, b.dev);
            check("regadr", regadr_o, b.regadr);
            check("datnum", datnum_o, b.num);
          end
          if (first_burst) check("first_enable_latency", cyc - start_cyc, 2);
          else             check("twr_gap", cyc - end_cyc, TWR + 2);
          first_burst = 0;
        end
        if (!enable_o && prev_en && !m_respond) check("ack_timeout_len", cyc - rise_cyc, ACK);
        if (done_o) done_cnt++;
        if (done_o && !prev_done && exp_done_gap) check("done_gap", cyc - end_cyc, TWR + 2);
        if (newdat_i && m_counting) exp_buf++;
      end
      if (prev_active && !m_active) end_cyc = cyc;
      prev_en = enable_o;
      prev_active = m_active;
      prev_done = done_o;
    end
  end

  task automatic wait_master_idle();
    int t = 0;
    while ((m_active || busy_i) && t < 300) begin @(negedge clock_i); t++; end
    repeat (8) @(negedge clock_i);
  endtask

  task automatic do_xfer(input int adr, input int len, input bit respond, input bit exp_err,
                         input bit inject);
    int nb, total, t;
    model_bursts(adr, len);
    exp_q = mq;
    if (!respond) while (exp_q.size() > 1) void'(exp_q.pop_back());
    nb = exp_q.size();
    total = respond ? ((len > 1024) ? 1024 : len) : 0;
    m_respond = respond;
    exp_done_gap = respond && (nb > 0);
    en_cnt = 0;
    done_cnt = 0;
    first_burst = 1;
    @(posedge clock_i); #1;
    start_i = 1'b1; adr_i = 10'(adr); len_i = 11'(len);
    start_cyc = cyc;
    exp_buf = 0;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    @(negedge clock_i);
    check("busy_after_start", busy_o, 1);
    check("err_cleared_on_start", err_o, 0);
    if (inject) begin
      repeat (10) @(posedge clock_i);
      #1; start_i = 1'b1; adr_i = 10'h155; len_i = 11'd3;
      @(posedge clock_i); #1;
      start_i = 1'b0;
    end
    t = 0;
    while (!done_o && t < 30000) begin @(negedge clock_i); t++; end
    check("done_seen", done_o, 1);
    check("err_at_done", err_o, exp_err);
    check("busy_low_at_done", busy_o, 0);
    check("bufadr_at_done", bufadr_o, 32'(total % 1024));
    check("bursts_left", exp_q.size(), 0);
    if (len == 0) check("zero_len_done_latency", cyc - start_cyc, 2);
    @(negedge clock_i);
    check("done_one_cycle", done_o, 0);
    wait_master_idle();
    check("done_count", done_cnt, 1);
    check("burst_count", en_cnt, nb);
  endtask

  initial begin
    int t;
    reset_i = 1'b1; start_i = 1'b0; adr_i = '0; len_i = '0;

    model_bursts('h00A, 20);
    check("model_a_size", mq.size(), 2);
    check("model_a0_num", mq[0].num, 6);
    check("model_a0_reg", mq[0].regadr, 'h0A);
    check("model_a1_num", mq[1].num, 14);
    check("model_a1_reg", mq[1].regadr, 'h10);
    model_bursts('h3FC, 8);
    check("model_b0_dev", mq[0].dev, 'h53);
    check("model_b0_reg", mq[0].regadr, 'hFC);
    check("model_b1_dev", mq[1].dev, 'h50);
    check("model_b1_reg", mq[1].regadr, 0);

    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    check("rst_enable", enable_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_bufadr", bufadr_o, 0);
    check("rst_datnum", datnum_o, 0);
    check("rst_devadr", devadr_o, 'h50);
    check("rst_regadr", regadr_o, 0);
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    chk_en = 1;

    do_xfer('h000, 16, 1, 0, 0);
    check("t1_bufadr_16", bufadr_o, 16);
    do_xfer('h00A, 20, 1, 0, 1);
    check("t2_bufadr_20", bufadr_o, 20);
    do_xfer('h3FC, 8, 1, 0, 0);
    do_xfer('h040, 0, 1, 0, 0);
    do_xfer('h123, 5, 0, 1, 0);
    check("err_sticky", err_o, 1);
    do_xfer('h200, 3, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      do_xfer($urandom_range(0, 1023), $urandom_range(0, 40), 1, 0, 0);
    end
    do_xfer($urandom_range(0, 1023), 1100, 1, 0, 0);

    // Reset in the middle of a burst.
    chk_en = 0;
    m_respond = 1;
    @(posedge clock_i); #1;
    start_i = 1'b1; adr_i = 10'h000; len_i = 11'd16;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    t = 0;
    while (bufadr_o < 10'd3 && t < 300) begin @(negedge clock_i); t++; end
    check("rst_test_reached_run", (bufadr_o >= 10'd3), 1);
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    check("midrst_enable", enable_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_bufadr", bufadr_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_datnum", datnum_o, 0);
    wait_master_idle();
    chk_en = 1;
    do_xfer('h055, 0, 1, 0, 0);
    do_xfer('h0F7, 12, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
